lp805x_ntmr_sched: RTL and testbench
====================================

// Module: lp805x_ntmr_sched
// PURPOSE
//  Shares one lp805x new-timer instance among NCH software/hardware requesters, each asking for a one-shot delay.
//  A round-robin arbiter picks a requester, and an FSM programs the timer over its MMIO write port (NTMRH, NTMRL, NTMRCTR).
//  The FSM waits for overflow, stops the timer, then signals completion to that requester.
//  Sits between requesting peripherals and the timer's SFR write side, in the timer clock domain.
// PARAMETERS
//  NCH       4      number of requesters (2..8)
//  PRESC     3'b000 prescale field written to NTMRCTR[7:5]
//  ADDR_TH   8'hC5  SFR address of NTMRH
//  ADDR_TL   8'hC4  SFR address of NTMRL
//  ADDR_CTR  8'hC3  SFR address of NTMRCTR
// PORTS
//  clk       in   1        block clock; one clock domain only
//  rst       in   1        synchronous, active-high reset
//  req       in   NCH      level request per channel; hold until ack
//  delay     in   16*NCH   delay per channel, in prescaled ticks; ch i = delay[16i+15:16i]
//  abort     in   1        cancel the channel currently served
//  ack       out  NCH      one-cycle pulse: request granted and delay latched
//  done      out  NCH      one-cycle pulse: delay elapsed (or aborted)
//  aborted   out  1        one-cycle pulse with done when completion was due to abort
//  busy      out  1        high in any state except IDLE
//  tmr_wr    out  1        timer write strobe; held until tmr_wrdy
//  tmr_addr  out  8        timer SFR address
//  tmr_data  out  8        timer write data
//  tmr_wrdy  in   1        timer accepts write this cycle when tmr_wr and tmr_wrdy
//  tmr_ovf   in   1        timer overflow/interrupt flag (ntf)
// BEHAVIOUR
//  Reset values: ack=0, done=0, aborted=0, busy=0, tmr_wr=0, tmr_addr=0, tmr_data=0.
//  Reset also clears the RR pointer to 0 and the FSM state to IDLE.
//  Reset mid-operation: timer is NOT written; the system reset resets the timer too.
//  FSM states: IDLE, LDH, LDL, START, WAIT, STOP, FIN.
//  IDLE: if any req bit is set, grant one channel by round-robin.
//   Search starts at ptr, ascending with wrap; the winner is g.
//   Latch load=16'h0000-delay[g]. Pulse ack[g] for 1 cycle. Set ptr=(g+1) mod NCH.
//   If delay[g]==0: go to FIN; done[g] fires next cycle and the timer is not touched.
//   Otherwise go to LDH.
//  LDH: tmr_wr=1, addr=ADDR_TH, data=load[15:8]; on tmr_wrdy go to LDL.
//  LDL: tmr_wr=1, addr=ADDR_TL, data=load[7:0]; on tmr_wrdy go to START.
//  START: tmr_wr=1, addr=ADDR_CTR, data={PRESC,5'b10010} (inc_timer=1, ie=1); on tmr_wrdy go to WAIT.
//  While a write is stalled (tmr_wrdy=0), tmr_wr, tmr_addr and tmr_data hold stable.
//  tmr_wr deasserts the cycle after the accepting edge unless the next state also writes.
//  WAIT: tmr_wr=0. On the rising edge of tmr_ovf, go to STOP.
//   tmr_ovf is registered internally for edge detection; latency is 1 cycle after ovf rises.
//   A tmr_ovf already high on entry to WAIT is not an edge; the flag is stale and is ignored.
//  STOP: tmr_wr=1, addr=ADDR_CTR, data={PRESC,5'b00000}; this stops the count and clears the flag. On tmr_wrdy go to FIN.
//  FIN: pulse done[g] (plus aborted if abort was taken); go to IDLE; arbitration resumes the next cycle.
//  abort: sampled in LDH, LDL, START and WAIT. It forces the next state to STOP.
//   A pending stalled write is dropped only after its acceptance, never torn.
//   abort in IDLE, STOP or FIN is ignored.
//  req of the served channel is ignored from ack until FIN.
//  If req is still high after done, that channel re-competes with the RR priority already advanced.
//  Arithmetic: load is a 16-bit modulo subtract. delay=1 gives load=FFFF, so overflow comes 1 tick after start.
//  busy = (state != IDLE).
//  ack and done are one-hot or zero.
// TESTING
//  1. req=4'b0001, delay0=16'h0003, tmr_wrdy=1 -> ack[0]; writes H=FF, L=FD, CTR=0x12; ovf rise -> CTR=0x00 write, then done[0].
//  2. req=4'b1111 held, all delays=5 -> grant order 0,1,2,3,0; exactly one ack per FIN cycle; no overlap.
//  3. tmr_wrdy low for 3 cycles during LDL -> tmr_wr, addr=ADDR_TL and data held for 4 cycles; single accepted write.
//  4. delay1=0, req=4'b0010 -> ack[1], done[1] two cycles later, tmr_wr never asserted.
//  5. abort pulse in WAIT -> CTR=0x00 write, done[g] with aborted=1; a later ovf is ignored in IDLE.
//  6. rst asserted in WAIT -> next cycle all outputs 0 and state IDLE; RR pointer=0 (req=4'b1111 grants ch0).

Source files
------------

// File: rtl/lp805x_ntmr_sched.sv
// lp805x_ntmr_sched: round-robin sharing of one lp805x new-timer among NCH one-shot delay requesters
module lp805x_ntmr_sched #(
  parameter int          NCH      = 4,
  parameter logic [2:0]  PRESC    = 3'b000,
  parameter logic [7:0]  ADDR_TH  = 8'hC5,
  parameter logic [7:0]  ADDR_TL  = 8'hC4,
  parameter logic [7:0]  ADDR_CTR = 8'hC3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    req,
  input  logic [16*NCH-1:0] delay,
  input  logic              abort,
  output logic [NCH-1:0]    ack,
  output logic [NCH-1:0]    done,
  output logic              aborted,
  output logic              busy,
  output logic              tmr_wr,
  output logic [7:0]        tmr_addr,
  output logic [7:0]        tmr_data,
  input  logic              tmr_wrdy,
  input  logic              tmr_ovf
);
  localparam int PW = $clog2(NCH);
  localparam logic [2:0] IDLE = 3'd0, LDH = 3'd1, LDL = 3'd2, START = 3'd3,
                         WAIT = 3'd4, STOP = 3'd5, FIN = 3'd6;
  localparam logic [NCH-1:0] ONE = {{(NCH-1){1'b0}}, 1'b1};
  logic [2:0]     state_q, state_d;
  logic [PW-1:0]  ptr_q, ptr_d, g_q, g_d;
  logic [15:0]    load_q, load_d;
  logic           ovf_q;
  logic           abrt_q, abrt_d;
  logic [NCH-1:0] done_q, done_d;
  logic           aborted_q, aborted_d;
  logic [PW-1:0]  lo, hi, win;
  logic           any_req, hit, grant, abort_now, pend, ovf_rise;
  logic [15:0]    dly_w;
  // lowest requester at or above ptr wins, else lowest overall (wrap)
  always_comb begin
    lo = '0;
    hi = '0;
    any_req = 1'b0;
    hit = 1'b0;
    for (int i = NCH-1; i >= 0; i--) begin
      if (req[i]) begin
        lo = PW'(i);
        any_req = 1'b1;
      end
      if (req[i] && PW'(i) >= ptr_q) begin
        hi = PW'(i);
        hit = 1'b1;
      end
    end
    win = hit ? hi : lo;
  end
  assign dly_w     = delay[{win, 4'd0} +: 16];
  assign grant     = state_q == IDLE && any_req;
  assign abort_now = abort && state_q inside {LDH, LDL, START, WAIT};
  assign pend      = abrt_q || abort_now;
  assign ovf_rise  = tmr_ovf && !ovf_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = any_req ? (dly_w == 16'h0000 ? FIN : LDH) : IDLE;
      LDH:     state_d = tmr_wrdy ? (pend ? STOP : LDL) : LDH;
      LDL:     state_d = tmr_wrdy ? (pend ? STOP : START) : LDL;
      START:   state_d = tmr_wrdy ? (pend ? STOP : WAIT) : START;
      WAIT:    state_d = (pend || ovf_rise) ? STOP : WAIT;
      STOP:    state_d = tmr_wrdy ? FIN : STOP;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    ptr_d     = grant ? (int'(win) == NCH-1 ? '0 : win + 1'b1) : ptr_q;
    g_d       = grant ? win : g_q;
    load_d    = grant ? 16'h0000 - dly_w : load_q;
    abrt_d    = (state_q == IDLE || state_q == FIN) ? 1'b0 : pend;
    done_d    = state_q == FIN ? ONE << g_q : '0;
    aborted_d = state_q == FIN && abrt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      g_q       <= '0;
      load_q    <= '0;
      ovf_q     <= 1'b0;
      abrt_q    <= 1'b0;
      done_q    <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      g_q       <= g_d;
      load_q    <= load_d;
      ovf_q     <= tmr_ovf;
      abrt_q    <= abrt_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end
  // write port is a pure function of state, so a stalled write holds by construction
  always_comb begin
    tmr_wr   = state_q inside {LDH, LDL, START, STOP};
    tmr_addr = state_q == LDH ? ADDR_TH :
               state_q == LDL ? ADDR_TL :
               (state_q == START || state_q == STOP) ? ADDR_CTR : 8'h00;
    tmr_data = state_q == LDH ? load_q[15:8] :
               state_q == LDL ? load_q[7:0] :
               state_q == START ? {PRESC, 5'b10010} :
               state_q == STOP ? {PRESC, 5'b00000} : 8'h00;
  end
  assign ack     = (grant && !rst) ? ONE << win : '0;
  assign done    = done_q;
  assign aborted = aborted_q;
  assign busy    = state_q != IDLE;
endmodule

// File: tb/tb_lp805x_ntmr_sched.sv
// tb_lp805x_ntmr_sched: randomized bench with a transaction-level scheduler/timer reference model
module tb_lp805x_ntmr_sched;
  localparam int NCH = 4;
  localparam int N_RST = 50;
  localparam int N_END = 60;
  localparam logic [7:0] TH = 8'hC5, TL = 8'hC4, CTR = 8'hC3;
  logic clk = 1'b0;
  logic rst, abort, aborted, busy, tmr_wr, tmr_wrdy, tmr_ovf;
  logic [NCH-1:0] req, ack, done;
  logic [16*NCH-1:0] delay;
  logic [7:0] tmr_addr, tmr_data;
  always #5 clk = ~clk;
  lp805x_ntmr_sched dut (
    .clk(clk), .rst(rst), .req(req), .delay(delay), .abort(abort),
    .ack(ack), .done(done), .aborted(aborted), .busy(busy),
    .tmr_wr(tmr_wr), .tmr_addr(tmr_addr), .tmr_data(tmr_data),
    .tmr_wrdy(tmr_wrdy), .tmr_ovf(tmr_ovf)
  );
  int checks = 0, failures = 0;
  int cyc = 0, ptr_m = 0, g_m = 0, n_done = 0, ack_cyc = -10;
  int stop_due = -1, done_due = -1, start_cyc = 0, ovf_at = 0, rst_cnt = 3;
  logic [15:0] dly_m;
  logic [15:0] q[$];
  logic [NCH-1:0] req_v = '0;
  logic serving = 0, trig = 0, abt_m = 0, running = 0, stale_m = 0;
  logic rst_chk = 0, did_rst = 0, exp0 = 0, ovf_prev = 0, prev_stall = 0, hung = 0;
  logic [7:0] pa, pd;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic int rr(input logic [NCH-1:0] r, input int p);
    for (int k = 0; k < NCH; k++)
      if (r[(p + k) % NCH]) return (p + k) % NCH;
    return -1;
  endfunction
  function automatic logic [15:0] rnd_delay();
    case ($urandom % 6)
      0: return 16'h0000;
      1: return 16'h0001;
      2: return 16'hFFFF;
      3: return 16'($urandom);
      default: return 16'($urandom_range(2, 20));
    endcase
  endfunction
  task automatic drive();
    rst = rst_cnt > 0;
    if (rst_cnt > 0) rst_cnt--;
    if (n_done >= N_RST && !did_rst && serving && running && q.size() == 1 && !trig && cyc < ovf_at) begin
      rst = 1'b1;
      did_rst = 1'b1;
    end
    if (n_done == 0 && !serving) begin
      req_v = 4'b0001;
      delay[15:0] = 16'h0003;
    end else if (n_done == 1 && !serving) begin
      req_v = 4'b0010;
      delay[31:16] = 16'h0000;
    end else if (n_done >= 2 && n_done < 10) begin
      req_v = '1;
      delay = {NCH{16'd5}};
    end else if (n_done >= 10) begin
      if (!serving && req_v == 0 && $urandom % 3 == 0) req_v = NCH'($urandom);
      if ($urandom % 4 == 0) req_v |= NCH'($urandom);
      if ($urandom % 4 == 0) delay[16*$urandom_range(0, NCH-1) +: 16] = rnd_delay();
    end
    req = (rst || rst_chk) ? '0 : req_v;
    tmr_wrdy = n_done < 10 ? 1'b1 : ($urandom % 3 != 0);
    abort = !rst && n_done >= 10 && serving && q.size() > 0 && !trig && $urandom % 30 == 0;
    if (rst) tmr_ovf = 1'b0;
    else if (!serving) tmr_ovf = ($urandom % 6 == 0);
    else if (running) tmr_ovf = cyc >= ovf_at || (stale_m && cyc < start_cyc + 5);
    else tmr_ovf = stale_m && q.size() == 2;
  endtask
  task automatic monitor();
    logic acc, was_wait;
    logic [15:0] w, ld;
    int e;
    if (rst) begin
      serving = 0; ptr_m = 0; q.delete(); running = 0; trig = 0; rst_chk = 1;
      prev_stall = 0; stop_due = -1; done_due = -1; req_v = '0; ovf_prev = tmr_ovf;
      return;
    end
    if (rst_chk) begin
      check("rst_ack", ack, 0);
      check("rst_done", done, 0);
      check("rst_aborted", aborted, 0);
      check("rst_busy", busy, 0);
      check("rst_wr", tmr_wr, 0);
      check("rst_addr", tmr_addr, 0);
      check("rst_data", tmr_data, 0);
      rst_chk = 0;
      if (did_rst) begin
        req_v = '1;
        exp0 = 1;
      end
      ovf_prev = tmr_ovf;
      return;
    end
    if (prev_stall) begin
      check("hold_wr", tmr_wr, 1);
      check("hold_addr", tmr_addr, pa);
      check("hold_data", tmr_data, pd);
    end
    was_wait = serving && running && q.size() == 1 && !trig;
    if (was_wait) check("early_stop", tmr_wr, 0);
    if (cyc == stop_due) check("stop_lat", {tmr_wr, tmr_addr, tmr_data}, {1'b1, CTR, 8'h00});
    acc = tmr_wr && tmr_wrdy;
    if (tmr_wr && q.size() == 0) check("wr_spur", tmr_wr, 0);
    if (acc && q.size() > 0) begin
      w = q.pop_front();
      check("wr", {tmr_addr, tmr_data}, w);
      if (w == {CTR, 8'h12}) begin
        running = 1;
        start_cyc = cyc;
        ovf_at = cyc + (stale_m ? 8 : 1) + (dly_m > 30 ? 30 : int'(dly_m));
      end
      if (w == {CTR, 8'h00}) begin
        running = 0;
        done_due = cyc + 2;
      end
    end
    if (abort) begin
      abt_m = 1;
      trig = 1;
    end
    if (abt_m && q.size() > 0 && (acc || was_wait)) begin
      while (q.size() > 1) void'(q.pop_front());
      stop_due = cyc + 1;
    end
    if (was_wait && !abort && tmr_ovf && !ovf_prev) begin
      trig = 1;
      stop_due = cyc + 1;
    end
    if (cyc == done_due) check("done_lat", done, 32'(1) << g_m);
    if (done != 0 || aborted) begin
      check("done_srv", serving, 1);
      check("done_ch", done, 32'(1) << g_m);
      check("done_abt", aborted, abt_m);
      check("done_wr_left", q.size(), 0);
      if (dly_m == 0) check("zero_lat", cyc - ack_cyc, 2);
      serving = 0;
      n_done++;
    end
    check("busy", busy, serving && ack_cyc != cyc);
    if (!serving) begin
      e = rr(req, ptr_m);
      check("ack", ack, e < 0 ? 0 : 32'(1) << e);
      if (e >= 0 && exp0) begin
        check("rst_rr", ack, 1);
        exp0 = 0;
      end
      if (e >= 0) begin
        g_m = e;
        ptr_m = (e + 1) % NCH;
        dly_m = delay[16*e +: 16];
        ld = 16'h0000 - dly_m;
        q.delete();
        if (dly_m != 0) q = '{{TH, ld[15:8]}, {TL, ld[7:0]}, {CTR, 8'h12}, {CTR, 8'h00}};
        done_due = dly_m == 0 ? cyc + 2 : -1;
        serving = 1; ack_cyc = cyc; abt_m = 0; trig = 0; running = 0;
        stale_m = n_done >= 10 && $urandom % 4 == 0;
        if (n_done < 2 || n_done >= 10) req_v[e] = 1'b0;
      end
    end else check("ack_busy", ack, 0);
    if (serving && cyc - ack_cyc > 500) begin
      check("xact_timeout", cyc - ack_cyc, 500);
      hung = 1;
    end
    prev_stall = tmr_wr && !tmr_wrdy;
    pa = tmr_addr;
    pd = tmr_data;
    ovf_prev = tmr_ovf;
  endtask
  task automatic step();
    @(negedge clk);
    cyc++;
    drive();
    #2;
    monitor();
  endtask
  initial begin
    rst = 1'b1; req = '0; delay = '0; abort = 1'b0; tmr_wrdy = 1'b0; tmr_ovf = 1'b0;
    while (!(did_rst && n_done >= N_END) && !hung && cyc < 60000) step();
    check("complete", did_rst && n_done >= N_END, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
